// File: rtl/mac_pe_pkg.sv
// Shared definitions for the MAC PE control register file and its command driver.
// Holds the register map, CTRL bit positions, op encodings and the driver state enum.
package mac_pe_pkg;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_X    = 2'd1;
    localparam logic [1:0] REG_Y    = 2'd2;
    localparam logic [1:0] REG_YOUT = 2'd3;

    localparam int CTRL_LOAD_WEIGHT = 0;
    localparam int CTRL_VALID_IN    = 1;

    localparam logic OP_LOAD    = 1'b0;
    localparam logic OP_COMPUTE = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        WR_X,
        WR_Y,
        CTRL_ON,
        CTRL_OFF,
        WAIT,
        RD_REQ,
        RD_WAIT,
        RESP
    } drv_state_t;

    // CTRL word that starts the given operation: one-hot on the matching bit.
    function automatic logic [31:0] ctrl_word(input logic op);
        ctrl_word = (op == OP_COMPUTE) ? (32'd1 << CTRL_VALID_IN) : (32'd1 << CTRL_LOAD_WEIGHT);
    endfunction

endpackage

// File: rtl/mac_pe_drv_cnt.sv
// Loadable down-counter with zero flag; shared by the PE-latency wait and the read timeout.
module mac_pe_drv_cnt #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mac_pe_driver.sv
// Expands load-weight / compute commands into MAC PE register writes, waits the PE latency,
// reads back y_out and returns it (or a timeout error) on the result port.
module mac_pe_driver
    import mac_pe_pkg::*;
#(
    parameter int PE_LAT     = 2,
    parameter int RD_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [7:0]  cmd_x,
    input  logic [31:0] cmd_y,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_err,
    output logic        busy,
    output logic [1:0]  reg_addr,
    output logic        reg_read,
    output logic        reg_write,
    output logic [31:0] reg_writedata,
    input  logic [31:0] reg_readdata,
    input  logic        reg_readdatavalid
);

    localparam int CNT_MAX = (PE_LAT > RD_TIMEOUT) ? PE_LAT : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    drv_state_t state, next_state;

    logic        op_q, nxt_op;
    logic [7:0]  x_q, nxt_x;
    logic [31:0] y_q, nxt_y;

    logic [1:0]  nxt_reg_addr;
    logic        nxt_reg_read, nxt_reg_write, nxt_res_valid, nxt_res_err;
    logic [31:0] nxt_reg_writedata, nxt_res_data;

    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_value;

    mac_pe_drv_cnt #(.W(CNT_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (cnt_load),
        .load_value (cnt_value),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            op_q          <= OP_LOAD;
            x_q           <= '0;
            y_q           <= '0;
            reg_addr      <= REG_CTRL;
            reg_read      <= 1'b0;
            reg_write     <= 1'b0;
            reg_writedata <= '0;
            res_valid     <= 1'b0;
            res_data      <= '0;
            res_err       <= 1'b0;
        end else begin
            state         <= next_state;
            op_q          <= nxt_op;
            x_q           <= nxt_x;
            y_q           <= nxt_y;
            reg_addr      <= nxt_reg_addr;
            reg_read      <= nxt_reg_read;
            reg_write     <= nxt_reg_write;
            reg_writedata <= nxt_reg_writedata;
            res_valid     <= nxt_res_valid;
            res_data      <= nxt_res_data;
            res_err       <= nxt_res_err;
        end
    end

    // Bus outputs are registered, so they are decoded from the state being entered.
    // Counters load N-1 so each waiting state lasts exactly N cycles.
    always_comb begin
        next_state        = state;
        nxt_op            = op_q;
        nxt_x             = x_q;
        nxt_y             = y_q;
        nxt_res_data      = res_data;
        nxt_res_err       = res_err;
        nxt_res_valid     = 1'b0;
        nxt_reg_addr      = REG_CTRL;
        nxt_reg_read      = 1'b0;
        nxt_reg_write     = 1'b0;
        nxt_reg_writedata = '0;
        cnt_load          = 1'b0;
        cnt_value         = '0;
        cnt_dec           = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    nxt_op     = cmd_op;
                    nxt_x      = cmd_x;
                    nxt_y      = cmd_y;
                    next_state = WR_X;
                end
            end
            WR_X:    next_state = (op_q == OP_COMPUTE) ? WR_Y : CTRL_ON;
            WR_Y:    next_state = CTRL_ON;
            CTRL_ON: next_state = CTRL_OFF;
            CTRL_OFF: begin
                if (op_q == OP_COMPUTE) begin
                    next_state = WAIT;
                    cnt_load   = 1'b1;
                    cnt_value  = CNT_W'(PE_LAT - 1);
                end else begin
                    next_state = IDLE;
                end
            end
            WAIT: begin
                if (cnt_zero) begin
                    next_state = RD_REQ;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_REQ: begin
                next_state = RD_WAIT;
                cnt_load   = 1'b1;
                cnt_value  = CNT_W'(RD_TIMEOUT - 1);
            end
            RD_WAIT: begin
                if (reg_readdatavalid) begin
                    nxt_res_data = reg_readdata;
                    nxt_res_err  = 1'b0;
                    next_state   = RESP;
                end else if (cnt_zero) begin
                    nxt_res_data = '0;
                    nxt_res_err  = 1'b1;
                    next_state   = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        case (next_state)
            WR_X: begin
                nxt_reg_write     = 1'b1;
                nxt_reg_addr      = REG_X;
                nxt_reg_writedata = {24'd0, nxt_x};
            end
            WR_Y: begin
                nxt_reg_write     = 1'b1;
                nxt_reg_addr      = REG_Y;
                nxt_reg_writedata = nxt_y;
            end
            CTRL_ON: begin
                nxt_reg_write     = 1'b1;
                nxt_reg_addr      = REG_CTRL;
                nxt_reg_writedata = ctrl_word(nxt_op);
            end
            CTRL_OFF: begin
                nxt_reg_write     = 1'b1;
                nxt_reg_addr      = REG_CTRL;
                nxt_reg_writedata = '0;
            end
            RD_REQ: begin
                nxt_reg_read = 1'b1;
                nxt_reg_addr = REG_YOUT;
            end
            RESP:    nxt_res_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: doc/mac_pe_driver.md
# mac_pe_driver

Register-bus initiator that drives the 2-bit-address MAC PE control register file from a simple command stream. Accepts load-weight and compute commands on a valid/ready port, expands each into the required sequence of single-cycle register writes, waits the PE latency, reads back the PE result (address 3) and returns it on a valid/ready result port. Sits between the NPU command scheduler and the PE control register block.

## Interface
- PE_LAT, 2: cycles waited after the valid_in clear write before the result read (≥1).
- RD_TIMEOUT, 16: max cycles waited for reg_readdatavalid after reg_read (≥2).
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high exactly when state is IDLE.
- cmd_op  in  1  0 = load weight, 1 = compute.
- cmd_x  in  8  weight (op 0) or activation (op 1), signed.
- cmd_y  in  32  partial sum in (op 1 only), signed.
- res_valid  out  1  result present (compute only).
- res_ready  in  1  result accepted.
- res_data  out  32  PE y_out, signed.
- res_err  out  1  read timed out; res_data = 0.
- busy  out  1  state != IDLE.
- reg_addr  out  2  register address.
- reg_read  out  1  read strobe, one cycle.
- reg_write  out  1  write strobe, one cycle.
- reg_writedata  out  32  write data.
- reg_readdata  in  32  read data.
- reg_readdatavalid  in  1  read data valid.

## Operation
- States: IDLE, WR_X, WR_Y, CTRL_ON, CTRL_OFF, WAIT, RD_REQ, RD_WAIT, RESP.
- IDLE: cmd_valid && cmd_ready captures cmd_op/x/y into internal registers -> WR_X.
- WR_X: reg_write=1, addr 1, data {24'd0, x} (zero-extended, no sign extension) -> compute ? WR_Y : CTRL_ON.
- WR_Y: reg_write=1, addr 2, data y -> CTRL_ON.
- CTRL_ON: reg_write=1, addr 0, data 32'h1 (load) or 32'h2 (compute) -> CTRL_OFF.
- CTRL_OFF: reg_write=1, addr 0, data 0 -> load ? IDLE : WAIT (counter loaded PE_LAT).
- WAIT: counter decrements; at zero -> RD_REQ.
- RD_REQ: reg_read=1, addr 3 -> RD_WAIT, timeout counter loaded RD_TIMEOUT.
- RD_WAIT: reg_readdatavalid -> capture res_data=reg_readdata, res_err=0, -> RESP; counter expires first -> res_data=0, res_err=1, -> RESP.
- RESP: res_valid=1, res_data/res_err stable until res_ready; on handshake -> IDLE.
- reg_readdatavalid outside RD_WAIT ignored. Strobes never overlap; read and write never in same cycle.
- cmd inputs ignored outside IDLE; command captured, so upstream may change them after handshake.
- Reset mid-sequence: all state returns to IDLE immediately; no cleanup write issued (PE block is reset by same rst_n).

## Timing
- All outputs registered except cmd_ready and busy (decoded from state register).
- Reset values: reg_addr 0, reg_read 0, reg_write 0, reg_writedata 0, res_valid 0, res_data 0, res_err 0, busy 0, cmd_ready 1.
- Compute, cmd accepted edge 0: writes in cycles 1–4 (x, y, ctrl 2, ctrl 0), WAIT cycles 5..4+PE_LAT, reg_read in cycle 5+PE_LAT; with 1-cycle responder latency readdatavalid cycle 6+PE_LAT, res_valid from cycle 7+PE_LAT.
- Load weight: writes in cycles 1–3 (x, ctrl 1, ctrl 0), cmd_ready high cycle 4.
- Result held indefinitely under res_ready=0; next command not accepted until RESP handshake.

## Structure
- Shared package mac_pe_pkg: register address constants (REG_CTRL=0, REG_X=1, REG_Y=2, REG_YOUT=3), CTRL bit positions (LOAD_WEIGHT=0, VALID_IN=1), op encodings, state enum.
- One sub-module: mac_pe_drv_cnt, loadable down-counter with zero flag, instanced once and shared by WAIT and RD_WAIT.

## Test plan
- Load weight x=8'hFD -> writes (1,0x000000FD),(0,0x1),(0,0x0) on cycles 1–3, no reg_read, no res_valid, cmd_ready back cycle 4.
- Compute x=3, y=100, responder returns 0x0000006A -> writes (1,3),(2,100),(0,2),(0,0), one read addr 3 at cycle 7 (PE_LAT=2), res_data=106, res_err=0.
- Responder never asserts readdatavalid -> after RD_TIMEOUT cycles res_valid=1, res_err=1, res_data=0.
- res_ready held low 10 cycles in RESP -> res_valid/res_data stable, cmd_ready=0, cmd_valid pulse ignored.
- Stray readdatavalid with 0xDEAD during WAIT -> ignored; later real read value returned.
- rst_n asserted in WAIT -> all outputs at reset values asynchronously; next compute runs full sequence correctly.
